// File: rtl/mul_rr_scheduler.sv
// Round-robin front end sharing one pipelined multiplier among NUM_REQ requesters.
// Each requester may have one operation in flight; products return through held response slots.
module mul_rr_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_LEN       = 32,
   parameter int PIPELINE_STAGE = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*DATA_LEN-1:0]  req_a,
   input  logic [NUM_REQ*DATA_LEN-1:0]  req_b,
   output logic [NUM_REQ-1:0]           rsp_valid,
   input  logic [NUM_REQ-1:0]           rsp_ready,
   output logic [NUM_REQ*DATA_LEN-1:0]  rsp_data,
   output logic [DATA_LEN-1:0]          mul_a,
   output logic [DATA_LEN-1:0]          mul_b,
   input  logic [DATA_LEN-1:0]          mul_result,
   output logic                         busy,
   output logic [31:0]                  done_count
);
   localparam int IDW  = $clog2(NUM_REQ);
   // Stage 0 sits alongside the mul_a/mul_b register; the remaining stages track the multiplier.
   localparam int TAGS = PIPELINE_STAGE + 1;

   logic [IDW-1:0]     rr_ptr;
   logic [NUM_REQ-1:0] pending;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] rsp_fire;
   logic               grant_vld;
   logic [IDW-1:0]     grant_id;
   logic [IDW-1:0]     scan_sel;
   int                 scan_idx;
   logic [TAGS-1:0]    tag_vld_p;
   logic [IDW-1:0]     tag_id_p [TAGS];

   assign elig     = req_valid & ~pending;
   assign rsp_fire = rsp_valid & rsp_ready;
   assign busy     = |pending;

   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      scan_idx  = 0;
      scan_sel  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = int'(rr_ptr) + k;
         if (scan_idx >= NUM_REQ)
            scan_idx = scan_idx - NUM_REQ;
         scan_sel = IDW'(scan_idx);
         if (!grant_vld && elig[scan_sel]) begin
            grant_vld = 1'b1;
            grant_id  = scan_sel;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant_vld)
         req_ready[grant_id] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_ptr     <= '0;
         pending    <= '0;
         tag_vld_p  <= '0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
         mul_a      <= '0;
         mul_b      <= '0;
         done_count <= '0;
         for (int s = 0; s < TAGS; s++)
            tag_id_p[s] <= '0;
      end else begin
         // issue stage: operands and owner tag enter together
         mul_a        <= grant_vld ? req_a[grant_id*DATA_LEN +: DATA_LEN] : '0;
         mul_b        <= grant_vld ? req_b[grant_id*DATA_LEN +: DATA_LEN] : '0;
         tag_vld_p[0] <= grant_vld;
         tag_id_p[0]  <= grant_id;
         for (int s = 1; s < TAGS; s++) begin
            tag_vld_p[s] <= tag_vld_p[s-1];
            tag_id_p[s]  <= tag_id_p[s-1];
         end
         if (grant_vld)
            rr_ptr <= (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;

         pending    <= (pending & ~rsp_fire) | req_ready;
         done_count <= done_count + 32'($countones(rsp_fire));

         // capture stage: the pending limit keeps the target slot empty here
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_fire[i])
               rsp_valid[i] <= 1'b0;
            if (tag_vld_p[TAGS-1] && tag_id_p[TAGS-1] == IDW'(i)) begin
               rsp_valid[i]                         <= 1'b1;
               rsp_data[i*DATA_LEN +: DATA_LEN]     <= mul_result;
            end
         end
      end
   end
endmodule
